// File: rtl/sm_input_debounce_pkg.sv
// Shared settings for the sm_* input-conditioning blocks: the default
// debounce window and the per-bit debounce FSM state encoding.
package sm_input_debounce_pkg;

    // Default debounce window in synchronized clkIn samples. Legal range is 2..65535.
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } db_state_e;

endpackage

// File: rtl/sm_debounce_bit.sv
// Debounces a single asynchronous input bit. The bit passes through a
// two-flop synchronizer and then a small FSM that accepts a new level only
// after DEBOUNCE_CYCLES consecutive samples disagree with the current clean
// level. On acceptance, the block drives a registered rise or fall pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_STABLE | sync2 agrees with the clean level; the counter is parked at 0
// ST_CHECK  | sync2 disagrees; the counter holds the disagreeing sample count
module sm_debounce_bit
    import sm_input_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clkIn,
    input  logic rst,
    input  logic raw_in,
    output logic clean_out,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Two-flop synchronizer: brings the raw level into the clkIn domain before any decision logic.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // State register, run-length counter, clean level and edge pulses.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state     <= ST_STABLE;
            cnt       <= '0;
            clean_out <= RESET_VALUE;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            clean_out <= clean_nxt;
            rise      <= rise_nxt;
            fall      <= fall_nxt;
        end
    end

    // Next-state logic. The counter only advances while in CHECK and never
    // passes CNT_LAST, because reaching CNT_LAST always leaves CHECK.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        clean_nxt = clean_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ST_STABLE: begin
                if (sync2 != clean_out) begin
                    state_nxt = ST_CHECK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (sync2 == clean_out) begin
                    // The disagreement did not last long enough: treat it as a glitch and drop it.
                    state_nxt = ST_STABLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_STABLE;
                    clean_nxt = sync2;
                    rise_nxt  = sync2;
                    fall_nxt  = ~sync2;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_STABLE;
            end
        endcase
    end

endmodule

// File: rtl/sm_input_debounce.sv
// Debounces a bank of DIP switches or keys. Each bit is handled by its own
// sm_debounce_bit instance. This level adds the any_change summary and a
// sticky ready flag, which rises once one full debounce window has elapsed
// since reset release.
module sm_input_debounce
    import sm_input_debounce_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change,
    output logic             ready
);

    // The ready counter must hold DEBOUNCE_CYCLES itself, so it needs one more code than the per-bit counter.
    localparam int               RDY_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RDY_W-1:0] RDY_ONE  = RDY_W'(1);
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RDY_W-1:0] RDY_FULL = RDY_W'(DEBOUNCE_CYCLES);

    logic [RDY_W-1:0] rdy_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clkIn     (clkIn),
            .rst       (rst),
            .raw_in    (raw_in[i]),
            .clean_out (clean_out[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

    // rise and fall are registered, so this OR lines up with them in the same cycle.
    assign any_change = |(rise | fall);

    // Count cycles since reset release and saturate at DEBOUNCE_CYCLES. The
    // ready flag is set on the edge where the count reaches DEBOUNCE_CYCLES.
    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            rdy_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            if (rdy_cnt != RDY_FULL) begin
                rdy_cnt <= rdy_cnt + RDY_ONE;
            end
            if (rdy_cnt == RDY_LAST) begin
                ready <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sm_input_debounce.md
SM_INPUT_DEBOUNCE -- requirements
Module: sm_input_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input bits (DIP switches/keys feeding the core's extraInput).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable synchronized samples required to accept a new level; legal range 2..65535.
REQ-003 Parameter RESET_VALUE, default all-zero (WIDTH bits), value of clean_out during and after reset.
REQ-004 clkIn  input  1  single clock; all flops on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 raw_in  input  WIDTH  asynchronous raw switch/key levels.
REQ-007 clean_out  output  WIDTH  debounced, synchronized levels.
REQ-008 rise  output  WIDTH  one-cycle pulse per bit when clean_out bit goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per bit when clean_out bit goes 1->0.
REQ-010 any_change  output  1  OR of all rise and fall bits, same cycle.
REQ-011 ready  output  1  high once DEBOUNCE_CYCLES cycles have elapsed since reset release; sticky until next reset.

Function
REQ-012 Each raw_in bit passes a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Per-bit FSM states: STABLE, CHECK; counter width = clog2(DEBOUNCE_CYCLES).
REQ-014 STABLE: sync2 == clean bit -> stay, counter 0; sync2 != clean bit -> CHECK, counter <= 1.
REQ-015 CHECK: sync2 == clean bit -> STABLE, counter <= 0, no output change (glitch rejected).
REQ-016 CHECK: sync2 != clean bit and counter == DEBOUNCE_CYCLES-1 -> clean bit <= sync2, rise/fall pulse, STABLE, counter <= 0.
REQ-017 CHECK: otherwise counter increments by 1; counter never wraps.
REQ-018 Latency: raw level held constant from sampling edge k -> clean_out updates at edge k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total).
REQ-019 rise/fall/any_change are registered, asserted exactly the cycle clean_out shows the new value, low otherwise.
REQ-020 Bits are fully independent; simultaneous transitions on several bits produce simultaneous pulses.
REQ-021 rise[i] and fall[i] are never high in the same cycle.
REQ-022 Glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no clean_out change and no pulse.
REQ-023 ready counter saturates at DEBOUNCE_CYCLES; clean_out is valid regardless of ready.

Reset
REQ-024 rst high asynchronously forces sync1 and sync2 to RESET_VALUE, clean_out to RESET_VALUE, FSMs to STABLE, counters to 0, rise/fall/any_change/ready to 0.
REQ-025 Reset asserted mid-CHECK aborts the pending transition with no pulse on release.
REQ-026 After release, a raw_in differing from RESET_VALUE is debounced normally (first update per REQ-018), producing a rise/fall pulse.

Structure
REQ-027 DEBOUNCE_CYCLES default and the STABLE/CHECK state encodings reside in the shared settings include used by the sm_* blocks.
REQ-028 Per-bit logic (synchronizer, FSM, counter, pulse flops) is sub-module sm_debounce_bit, instantiated WIDTH times via generate.
REQ-029 sm_input_debounce holds only the generate loop, any_change OR-reduction and the ready counter.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 8, RESET_VALUE = 0)
REQ-030 raw_in 0x00->0x01 held -> clean_out = 0x01 and rise = 0x01 for one cycle, exactly 6 edges after first sampling edge; any_change high that cycle.
REQ-031 raw_in bit 0 high for 3 cycles then low -> clean_out stays 0x00, no rise/fall/any_change.
REQ-032 clean_out = 0xFF, raw_in -> 0x0F -> clean_out = 0x0F, fall = 0xF0 one cycle, rise = 0x00.
REQ-033 rst pulsed while bit 2 is in CHECK -> clean_out = 0x00 immediately, no pulse; after release with raw_in bit 2 still high, rise = 0x04 six edges later.
REQ-034 Release rst -> ready low for 3 edges, high from the 4th edge, stays high across later input activity.
REQ-035 raw_in bit 5 toggling every 2 cycles for 40 cycles then held 1 -> exactly one rise[5] pulse, after the hold.
